apb_reg_slave: RTL and testbench
================================

Name: apb_reg_slave

Overview:
- APB completer (slave) stage that consumes transfers driven onto the team's APB bus by the master side and answers them.
- Contains a small word-addressed register file plus a read-only completed-transfer counter.
- Adds a fixed, parameterised number of wait states and signals errors through slv_err.
- Is the direct downstream consumer of the bus signals the master drives: addr, prot, sel, enable, write, wdata, strb.

Parameters:
ADDR_WIDTH, 3, addr bus is ADDR_WIDTH+1 bits wide ([ADDR_WIDTH:0]); value is a word index
SEL_WIDTH, 2, width of sel bus
SEL_INDEX, 0, sel bit that selects this slave (0..SEL_WIDTH-1)
WRITE_WIDTH, 32, wdata width
READ_WIDTH, WRITE_WIDTH, rdata width (must equal WRITE_WIDTH)
STRB_WIDTH, ceil(WRITE_WIDTH/8), byte strobe width (derived localparam)
NUM_REGS, 8, implemented word locations (2..2**(ADDR_WIDTH+1))
WAIT_STATES, 0, ready-low access cycles inserted before completion (0..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
addr  input  ADDR_WIDTH+1  word index
prot  input  3  protection; prot[0]=privileged
sel  input  SEL_WIDTH  slave selects
enable  input  1  access phase
write  input  1  1=write, 0=read
wdata  input  WRITE_WIDTH  write data
strb  input  STRB_WIDTH  write byte lanes
ready  output  1  transfer complete (registered)
rdata  output  READ_WIDTH  read data (registered)
slv_err  output  1  transfer error (registered, valid with ready)

Behaviour:
- Reset (reset=1 at a clk edge) forces the following, regardless of state or ongoing transfer:
  - state=IDLE; ready=0, rdata=0, slv_err=0.
  - All registers and the counter cleared to 0.
  - Any pending write is discarded.
- Map:
  - Index 0: control register. Writes require prot[0]=1.
  - Indices 1..NUM_REGS-2: plain RW storage.
  - Index NUM_REGS-1: read-only 32-bit counter of completed error-free transfers (reads and writes).
  - Index >= NUM_REGS: unmapped.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On sel[SEL_INDEX]=1 and enable=0 (setup phase), latch addr, write, wdata, strb, prot.
  - Then go to WAIT (load wait counter with WAIT_STATES-1), or to RESP if WAIT_STATES=0.
  - Otherwise stay in IDLE.
- WAIT:
  - ready=0. Decrement the counter each cycle.
  - At 0, go to RESP.
  - If sel[SEL_INDEX]=0 in any WAIT cycle (protocol abort): go to IDLE, no write, no count, no response.
- RESP:
  - ready=1 for exactly one cycle, then go to IDLE. Back-to-back transfers are therefore separated by the master's setup cycle.
  - Entering RESP registers rdata and slv_err.
  - The write commits at the clock edge that ends RESP, per byte lane i where strb[i]=1.
- Latency: with WAIT_STATES=N, ready rises in access cycle N+1 (the first access cycle if N=0).
- slv_err=1 cases:
  - Unmapped index.
  - Write to NUM_REGS-1.
  - Write to index 0 with prot[0]=0.
  - Erroring writes change no state. Erroring transfers return rdata=0 and do not increment the counter.
- rdata:
  - Read of a valid index: register value.
  - Writes: rdata=0.
  - rdata=0 whenever ready=0.
- Strobes: strb=0 on a valid write completes OKAY with no data change and does increment the counter.
- Counter increments by 1 at the end of each error-free RESP and wraps 0xFFFFFFFF -> 0.
  - A read of the counter returns the value before that read's own increment.
- Simultaneous events:
  - Setup to another sel bit is ignored.
  - Setup seen during WAIT or RESP is not captured. The master must hold setup until the slave is back in IDLE; a setup cycle that coincides with RESP is lost.
- Reset during WAIT or RESP aborts the transfer; ready stays 0.

Test Plan:
- Reset, then read indices 0..7 with WAIT_STATES=0 -> every read: ready high in the first access cycle, rdata=0, slv_err=0 (counter read returns 7, pre-increment).
- Write 0xDEADBEEF to index 3 with strb=4'b0101, then read index 3 -> rdata=0x00AD00EF, slv_err=0.
- Write to index 0 with prot=3'b000, then with prot=3'b001, value 0x12345678; read index 0 -> first write slv_err=1; read returns 0x12345678.
- Access index 9 and write index 7 -> both slv_err=1, rdata=0; counter unchanged on a subsequent read.
- WAIT_STATES=3: read -> ready low for 3 access cycles, high on the 4th; drop sel after 1 wait cycle -> no ready and no counter change.
- Assert reset during WAIT of a write to index 2 -> ready stays 0; index 2 reads 0 afterwards.

Source files
------------

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer with a word register file, completed-transfer counter and fixed wait states
module apb_reg_slave #(
    parameter int ADDR_WIDTH  = 3,
    parameter int SEL_WIDTH   = 2,
    parameter int SEL_INDEX   = 0,
    parameter int WRITE_WIDTH = 32,
    parameter int READ_WIDTH  = WRITE_WIDTH,
    parameter int NUM_REGS    = 8,
    parameter int WAIT_STATES = 0,
    localparam int STRB_WIDTH = (WRITE_WIDTH + 7) / 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH:0]    addr,
    input  logic [2:0]             prot,
    input  logic [SEL_WIDTH-1:0]   sel,
    input  logic                   enable,
    input  logic                   write,
    input  logic [WRITE_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0]  strb,
    output logic                   ready,
    output logic [READ_WIDTH-1:0]  rdata,
    output logic                   slv_err
);
    localparam int IW = $clog2(NUM_REGS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t                 state_q;
    logic [3:0]             wait_q;
    logic [ADDR_WIDTH:0]    addr_q;
    logic                   write_q, priv_q;
    logic [WRITE_WIDTH-1:0] wdata_q, mask;
    logic [STRB_WIDTH-1:0]  strb_q;
    logic [WRITE_WIDTH-1:0] regs_q [2**IW];
    logic [31:0]            cnt_q;
    logic                   ready_q, err_q;
    logic [READ_WIDTH-1:0]  rdata_q;
    logic                   setup, w, p, err;
    logic [ADDR_WIDTH:0]    a;
    int                     ai;
    logic [READ_WIDTH-1:0]  rd, resp;
    logic                   unused_bits;
    assign unused_bits = ^{prot[2:1], sel};
    assign setup = sel[SEL_INDEX] && !enable;
    // In IDLE the response is built straight from the setup phase so zero wait states still answer in the first access cycle
    assign a    = (state_q == IDLE) ? addr : addr_q;
    assign w    = (state_q == IDLE) ? write : write_q;
    assign p    = (state_q == IDLE) ? prot[0] : priv_q;
    assign ai   = int'(a);
    assign err  = ai >= NUM_REGS || (w && (ai == NUM_REGS - 1 || (ai == 0 && !p)));
    assign rd   = (ai == NUM_REGS - 1) ? READ_WIDTH'(cnt_q) : regs_q[a[IW-1:0]];
    assign resp = (err || w) ? '0 : rd;
    always_comb begin
        mask = '0;
        for (int b = 0; b < WRITE_WIDTH; b++) mask[b] = strb_q[b / 8];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            priv_q  <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < 2**IW; i++) regs_q[i] <= '0;
        end else begin
            ready_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: if (setup) begin
                    addr_q  <= addr;
                    write_q <= write;
                    priv_q  <= prot[0];
                    wdata_q <= wdata;
                    strb_q  <= strb;
                    if (WAIT_STATES == 0) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                        rdata_q <= resp;
                        err_q   <= err;
                    end else begin
                        state_q <= WAIT;
                        wait_q  <= 4'(WAIT_STATES - 1);
                    end
                end
                WAIT: if (!sel[SEL_INDEX]) begin
                    state_q <= IDLE;
                end else if (wait_q == '0) begin
                    state_q <= RESP;
                    ready_q <= 1'b1;
                    rdata_q <= resp;
                    err_q   <= err;
                end else begin
                    wait_q <= wait_q - 4'd1;
                end
                RESP: begin
                    state_q <= IDLE;
                    if (!err_q) begin
                        cnt_q <= cnt_q + 32'd1;
                        if (write_q) regs_q[addr_q[IW-1:0]] <= (regs_q[addr_q[IW-1:0]] & ~mask) | (wdata_q & mask);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ready   = ready_q;
    assign rdata   = rdata_q;
    assign slv_err = err_q;
endmodule

// File: tb/tb_apb_reg_slave.sv
// tb_apb_reg_slave: two completers (0 and 3 wait states) on one bus, checked each cycle against a behavioural model
module tb_apb_reg_slave;
    logic        clk = 1'b0, reset = 1'b1;
    logic [3:0]  addr = '0;
    logic [2:0]  prot = '0;
    logic [1:0]  sel = '0;
    logic        enable = 1'b0, write = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  strb = '0;
    logic [1:0]  rdy, er;
    logic [1:0][31:0] rd;
    logic [31:0] m_regs [2][8];
    logic [31:0] m_cnt [2];
    logic        exp_rdy [2];
    logic        exp_err [2];
    logic [31:0] exp_rd [2];
    bit          chk_en = 1'b0;
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    apb_reg_slave #(.SEL_INDEX(0), .WAIT_STATES(0)) d0 (
        .clk(clk), .reset(reset), .addr(addr), .prot(prot), .sel(sel), .enable(enable),
        .write(write), .wdata(wdata), .strb(strb), .ready(rdy[0]), .rdata(rd[0]), .slv_err(er[0]));
    apb_reg_slave #(.SEL_INDEX(1), .WAIT_STATES(3)) d3 (
        .clk(clk), .reset(reset), .addr(addr), .prot(prot), .sel(sel), .enable(enable),
        .write(write), .wdata(wdata), .strb(strb), .ready(rdy[1]), .rdata(rd[1]), .slv_err(er[1]));

    always @(negedge clk) if (chk_en) begin
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (rdy[k] !== exp_rdy[k]) begin
                n_err++;
                $display("FAIL ready[%0d] t=%0t: got %b want %b", k, $time, rdy[k], exp_rdy[k]);
            end
            n_cmp++;
            if (rd[k] !== exp_rd[k]) begin
                n_err++;
                $display("FAIL rdata[%0d] t=%0t: got %h want %h", k, $time, rd[k], exp_rd[k]);
            end
            if (exp_rdy[k]) begin
                n_cmp++;
                if (er[k] !== exp_err[k]) begin
                    n_err++;
                    $display("FAIL slv_err[%0d] t=%0t: got %b want %b", k, $time, er[k], exp_err[k]);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = '0;
            for (int i = 0; i < 8; i++) m_regs[k][i] = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // mode: 0 normal, 1 drop sel in access cycle cut, 2 assert reset in access cycle cut
    task automatic xfer(input int k, input logic [3:0] a, input bit w, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p, input int mode, input int cut,
                        output logic [31:0] got, output logic got_err, output int lat);
        int  n;
        bit  e;
        logic [31:0] r;
        n = (k == 1) ? 3 : 0;
        e = (a >= 8) || (w && (a == 7 || (a == 0 && !p[0])));
        r = (e || w) ? 32'h0 : ((a == 7) ? m_cnt[k] : m_regs[k][a[2:0]]);
        got = '0;
        got_err = 1'b0;
        lat = 0;
        sel = (k == 0) ? 2'b01 : 2'b10;
        enable = 1'b0;
        addr = a; write = w; wdata = d; strb = s; prot = p;
        idle(1);
        enable = 1'b1;
        for (int c = 1; c <= n + 1; c++) begin
            if (mode != 0 && c == cut) begin
                if (mode == 1) begin
                    sel = '0;
                    enable = 1'b0;
                end else reset = 1'b1;
                idle(1);
                if (mode == 2) begin
                    reset = 1'b0;
                    model_clear();
                end
                sel = '0;
                enable = 1'b0;
                return;
            end
            if (c == n + 1) begin
                exp_rdy[k] = 1'b1;
                exp_rd[k] = r;
                exp_err[k] = e;
            end
            @(negedge clk);
            if (rdy[k] && lat == 0) begin
                lat = c;
                got = rd[k];
                got_err = er[k];
            end
            @(posedge clk);
            #1;
        end
        exp_rdy[k] = 1'b0;
        exp_rd[k] = '0;
        exp_err[k] = 1'b0;
        if (!e) begin
            m_cnt[k] = m_cnt[k] + 32'd1;
            if (w) for (int i = 0; i < 4; i++) if (s[i]) m_regs[k][a[2:0]][8*i +: 8] = d[8*i +: 8];
        end
        sel = '0;
        enable = 1'b0;
    endtask

    initial begin
        logic [31:0] g;
        logic ge;
        int lat;
        model_clear();
        for (int k = 0; k < 2; k++) begin
            exp_rdy[k] = 1'b0;
            exp_rd[k] = '0;
            exp_err[k] = 1'b0;
        end
        idle(2);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_ready", {30'd0, rdy}, 32'd0);
        check("reset_rdata0", rd[0], 32'd0);
        idle(1);
        for (int i = 0; i < 8; i++) begin
            xfer(0, 4'(i), 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
            check($sformatf("init_read%0d", i), g, (i == 7) ? 32'd7 : 32'd0);
            check($sformatf("init_lat%0d", i), 32'(lat), 32'd1);
        end
        xfer(0, 4'd3, 1'b1, 32'hDEADBEEF, 4'b0101, 3'b000, 0, 0, g, ge, lat);
        xfer(0, 4'd3, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("strb_read", g, 32'h00AD00EF);
        xfer(0, 4'd0, 1'b1, 32'h12345678, 4'hF, 3'b000, 0, 0, g, ge, lat);
        check("ctrl_unpriv_err", {31'd0, ge}, 32'd1);
        xfer(0, 4'd0, 1'b1, 32'h12345678, 4'hF, 3'b001, 0, 0, g, ge, lat);
        check("ctrl_priv_err", {31'd0, ge}, 32'd0);
        xfer(0, 4'd0, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("ctrl_read", g, 32'h12345678);
        xfer(0, 4'd9, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("unmapped_err", {31'd0, ge}, 32'd1);
        xfer(0, 4'd7, 1'b1, 32'h5555AAAA, 4'hF, 3'b001, 0, 0, g, ge, lat);
        check("cnt_write_err", {31'd0, ge}, 32'd1);
        xfer(0, 4'd7, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("cnt_after_errs", g, 32'd12);
        xfer(0, 4'd1, 1'b1, 32'hFFFFFFFF, 4'b0000, 3'b000, 0, 0, g, ge, lat);
        xfer(0, 4'd1, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("strb0_read", g, 32'd0);
        xfer(1, 4'd7, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("ws3_lat", 32'(lat), 32'd4);
        check("ws3_cnt0", g, 32'd0);
        xfer(1, 4'd7, 1'b0, '0, '0, '0, 1, 2, g, ge, lat);
        idle(2);
        xfer(1, 4'd7, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("ws3_cnt_after_abort", g, 32'd1);
        xfer(1, 4'd2, 1'b1, 32'hCAFEF00D, 4'hF, 3'b000, 2, 2, g, ge, lat);
        idle(1);
        xfer(1, 4'd2, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("reset_mid_write", g, 32'd0);
        xfer(0, 4'd3, 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        check("reset_cleared_d0", g, 32'd0);
        for (int t = 0; t < 300; t++) begin
            int k, mode;
            k = int'($urandom_range(0, 1));
            mode = (k == 1 && $urandom_range(0, 7) == 0) ? 1 : 0;
            xfer(k, 4'($urandom_range(0, 15)), 1'($urandom), $urandom,
                 ($urandom_range(0, 5) == 0) ? 4'b0 : 4'($urandom), 3'($urandom),
                 mode, int'($urandom_range(1, 3)), g, ge, lat);
            idle(int'($urandom_range(0, 2)));
        end
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) xfer(k, 4'(i), 1'b0, '0, '0, '0, 0, 0, g, ge, lat);
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
